// File: rtl/nearest_block_reducer.sv
// Reduces each pixel's group of per-block intersection beats to the nearest visible block.
// One registered result per pixel; a stray index-0 beat mid-group restarts the group.
module nearest_block_reducer #(
    parameter int unsigned NUM_BLOCKS = 13
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [31:0] ray_x_in,
    input  logic [31:0] ray_y_in,
    input  logic [31:0] ray_z_in,
    input  logic [3:0]  block_index_in,
    input  logic        intersect_in,
    input  logic [31:0] t_in,
    input  logic        valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [31:0] ray_x_out,
    output logic [31:0] ray_y_out,
    output logic [31:0] ray_z_out,
    output logic        hit_out,
    output logic [3:0]  block_index_out,
    output logic [31:0] t_out,
    output logic        valid_out,
    output logic        sync_err_out
);

    localparam logic [3:0]  LastCnt = 4'(NUM_BLOCKS - 1);
    localparam logic [31:0] PosInf  = 32'h7F80_0000;

    logic [3:0]  cnt_q;
    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic [31:0] ray_x_q, ray_y_q, ray_z_q;
    logic        acc_hit_q;
    logic [3:0]  acc_idx_q;
    logic [31:0] acc_t_q;

    logic        resync, start, last;
    logic [3:0]  cnt_eff;
    logic        base_hit;
    logic [3:0]  base_idx;
    logic [31:0] base_t;
    logic        t_is_nan, candidate, take;
    logic        acc_hit_d;
    logic [3:0]  acc_idx_d;
    logic [31:0] acc_t_d;
    logic [10:0] cur_x;
    logic [9:0]  cur_y;
    logic [31:0] cur_ray_x, cur_ray_y, cur_ray_z;

    always_comb begin
        resync   = valid_in && (block_index_in == 4'd0) && (cnt_q != 4'd0);
        start    = (cnt_q == 4'd0) || resync;
        cnt_eff  = start ? 4'd0 : cnt_q;
        last     = (cnt_eff == LastCnt);

        // Group start seeds the accumulator instead of using stale state.
        base_hit = start ? 1'b0 : acc_hit_q;
        base_idx = start ? 4'd0 : acc_idx_q;
        base_t   = start ? PosInf : acc_t_q;

        t_is_nan  = (&t_in[30:23]) && (|t_in[22:0]);
        candidate = intersect_in && !t_in[31] && !t_is_nan;
        // Non-negative IEEE singles order the same as their magnitude bits.
        take      = candidate && (t_in[30:0] < base_t[30:0]);

        acc_hit_d = take ? 1'b1 : base_hit;
        acc_idx_d = take ? block_index_in : base_idx;
        acc_t_d   = take ? t_in : base_t;

        cur_x     = start ? x_in : x_q;
        cur_y     = start ? y_in : y_q;
        cur_ray_x = start ? ray_x_in : ray_x_q;
        cur_ray_y = start ? ray_y_in : ray_y_q;
        cur_ray_z = start ? ray_z_in : ray_z_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q           <= 4'd0;
            x_q             <= '0;
            y_q             <= '0;
            ray_x_q         <= '0;
            ray_y_q         <= '0;
            ray_z_q         <= '0;
            acc_hit_q       <= 1'b0;
            acc_idx_q       <= 4'd0;
            acc_t_q         <= PosInf;
            x_out           <= '0;
            y_out           <= '0;
            ray_x_out       <= '0;
            ray_y_out       <= '0;
            ray_z_out       <= '0;
            hit_out         <= 1'b0;
            block_index_out <= 4'd0;
            t_out           <= PosInf;
            valid_out       <= 1'b0;
            sync_err_out    <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            sync_err_out <= resync;
            if (valid_in) begin
                x_q       <= cur_x;
                y_q       <= cur_y;
                ray_x_q   <= cur_ray_x;
                ray_y_q   <= cur_ray_y;
                ray_z_q   <= cur_ray_z;
                acc_hit_q <= acc_hit_d;
                acc_idx_q <= acc_idx_d;
                acc_t_q   <= acc_t_d;
                if (last) begin
                    cnt_q           <= 4'd0;
                    x_out           <= cur_x;
                    y_out           <= cur_y;
                    ray_x_out       <= cur_ray_x;
                    ray_y_out       <= cur_ray_y;
                    ray_z_out       <= cur_ray_z;
                    hit_out         <= acc_hit_d;
                    block_index_out <= acc_idx_d;
                    t_out           <= acc_t_d;
                    valid_out       <= 1'b1;
                end else begin
                    cnt_q <= cnt_eff + 4'd1;
                end
            end
        end
    end

endmodule
